spi_slave_ctrl: RTL and testbench

SPI slave controller bridging an external SPI master to an on-chip host. Transmit bytes are fetched from a host TX FIFO and shifted out on MISO; received MOSI bytes are presented to the host as dout/dout_valid pulses. A byte-wide configuration port sets the SPI mode (CPOL/CPHA) and the inactivity timeout. All SPI inputs are oversampled in the system clock domain.

---
 rtl/spi_slave_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl.sv
// SPI slave controller: oversampled SPI front end, TX byte fetch from a host FIFO,
// RX byte delivery to the host, mode/timeout configuration port and SCK inactivity timeout.
module spi_slave_ctrl #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned TIMEOUT_DEFAULT = 127,
    parameter int unsigned TIMEOUT_SCALE   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_req_data,
    input  logic [DATA_WIDTH-1:0] fifo_din,
    input  logic                  fifo_din_valid,
    input  logic                  fifo_empty,
    input  logic [7:0]            reg_din,
    input  logic                  reg_din_val,
    output logic                  reg_ack,
    output logic                  timeout,
    output logic                  busy,
    output logic                  interrupt,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic                  spi_ss
);

    localparam int unsigned BIT_W     = $clog2(DATA_WIDTH);
    localparam int unsigned TO_W      = $clog2(127 * TIMEOUT_SCALE + 1);
    localparam int unsigned LOAD_WAIT = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_XFER
    } state_t;

    state_t state, state_next;

    logic [1:0] sck_sync, mosi_sync, ss_sync;
    logic       sck_d, ss_d;

    logic       cpol, cpha;
    logic [6:0] to_field;
    logic       mode_pend, to_pend;
    logic [1:0] mode_pend_val;
    logic [6:0] to_pend_val;

    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] rx_sr, tx_sr;
    logic [2:0]            wait_cnt;
    logic [TO_W-1:0]       to_cnt, to_limit;
    logic                  timed_out;

    logic sck_rise, sck_fall, sck_edge, lead_edge, trail_edge;
    logic ss_fall, ss_rise;
    logic sample_edge, shift_edge, byte_done, to_fire, apply_now;
    logic req_fetch, load_fifo, load_zero, end_xfer;

    // SS synchronisers reset to the asserted level so a master still holding SS low
    // across a reset is not mistaken for a new transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            ss_sync   <= '0;
            sck_d     <= 1'b0;
            ss_d      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            ss_sync   <= {ss_sync[0], spi_ss};
            sck_d     <= sck_sync[1];
            ss_d      <= ss_sync[1];
        end
    end

    assign busy       = (state != S_IDLE);
    assign sck_rise   = sck_sync[1] & ~sck_d;
    assign sck_fall   = ~sck_sync[1] & sck_d;
    assign sck_edge   = sck_rise | sck_fall;
    assign lead_edge  = cpol ? sck_fall : sck_rise;
    assign trail_edge = cpol ? sck_rise : sck_fall;
    assign ss_fall    = ss_d & ~ss_sync[1];
    assign ss_rise    = ~ss_d & ss_sync[1];

    // The MISO edge that coincides with bit 0 of a byte is skipped: for CPHA=0 it follows
    // the final sample (next byte already loaded), for CPHA=1 the MSB is already showing.
    assign sample_edge = busy & (cpha ? trail_edge : lead_edge);
    assign shift_edge  = busy & (cpha ? lead_edge : trail_edge) & (bit_cnt != '0);
    assign byte_done   = sample_edge & (bit_cnt == BIT_W'(DATA_WIDTH - 1));

    assign to_limit = TO_W'(to_field) * TO_W'(TIMEOUT_SCALE);
    assign to_fire  = busy & ~timed_out & (to_field != '0) & ~sck_edge & (to_cnt == to_limit);

    assign spi_miso = busy & tx_sr[DATA_WIDTH-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_fetch  = 1'b0;
        load_fifo  = 1'b0;
        load_zero  = 1'b0;
        end_xfer   = 1'b0;
        case (state)
            S_IDLE: begin
                if (ss_fall) begin
                    if (!fifo_empty) begin
                        req_fetch  = 1'b1;
                        state_next = S_LOAD;
                    end else begin
                        load_zero  = 1'b1;
                        state_next = S_XFER;
                    end
                end
            end
            S_LOAD: begin
                if (ss_rise) begin
                    end_xfer   = 1'b1;
                    state_next = S_IDLE;
                end else if (fifo_din_valid) begin
                    load_fifo  = 1'b1;
                    state_next = S_XFER;
                end else if (wait_cnt == 3'(LOAD_WAIT - 1)) begin
                    load_zero  = 1'b1;
                    state_next = S_XFER;
                end
            end
            S_XFER: begin
                if (ss_rise) begin
                    end_xfer   = 1'b1;
                    state_next = S_IDLE;
                end else if (byte_done) begin
                    if (!fifo_empty) begin
                        req_fetch  = 1'b1;
                        state_next = S_LOAD;
                    end else begin
                        load_zero = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (req_fetch) begin
            wait_cnt <= '0;
        end else if (state == S_LOAD) begin
            wait_cnt <= wait_cnt + 3'd1;
        end
    end

    // Writes arriving mid-transaction are parked and take effect as busy falls;
    // a write in the very cycle busy falls is applied directly.
    assign apply_now = ~busy | end_xfer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_ack       <= 1'b0;
            cpol          <= 1'b0;
            cpha          <= 1'b0;
            to_field      <= 7'(TIMEOUT_DEFAULT);
            mode_pend     <= 1'b0;
            to_pend       <= 1'b0;
            mode_pend_val <= '0;
            to_pend_val   <= '0;
        end else begin
            reg_ack <= reg_din_val;
            if (end_xfer) begin
                if (mode_pend) begin
                    {cpol, cpha} <= mode_pend_val;
                end
                if (to_pend) begin
                    to_field <= to_pend_val;
                end
                mode_pend <= 1'b0;
                to_pend   <= 1'b0;
            end
            if (reg_din_val) begin
                if (reg_din[7]) begin
                    if (apply_now) begin
                        to_field <= reg_din[6:0];
                    end else begin
                        to_pend     <= 1'b1;
                        to_pend_val <= reg_din[6:0];
                    end
                end else begin
                    if (apply_now) begin
                        {cpol, cpha} <= reg_din[1:0];
                    end else begin
                        mode_pend     <= 1'b1;
                        mode_pend_val <= reg_din[1:0];
                    end
                end
            end
        end
    end

    // After a timeout the counter parks until the next SCK edge so it pulses only once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt    <= '0;
            timed_out <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= to_fire;
            if (!busy || sck_edge) begin
                to_cnt    <= '0;
                timed_out <= 1'b0;
            end else if (to_fire) begin
                to_cnt    <= '0;
                timed_out <= 1'b1;
            end else if (!timed_out && to_field != '0) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt       <= '0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            dout          <= '0;
            dout_valid    <= 1'b0;
            fifo_req_data <= 1'b0;
            interrupt     <= 1'b0;
        end else begin
            fifo_req_data <= req_fetch;
            interrupt     <= end_xfer;
            dout_valid    <= byte_done;
            if (byte_done) begin
                dout <= {rx_sr[DATA_WIDTH-2:0], mosi_sync[1]};
            end
            if (end_xfer || to_fire) begin
                bit_cnt <= '0;
                rx_sr   <= '0;
            end else if (sample_edge) begin
                rx_sr   <= {rx_sr[DATA_WIDTH-2:0], mosi_sync[1]};
                bit_cnt <= byte_done ? '0 : bit_cnt + 1'b1;
            end
            if (end_xfer || load_zero) begin
                tx_sr <= '0;
            end else if (load_fifo) begin
                tx_sr <= fifo_din;
            end else if (shift_edge) begin
                tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl: an SPI master model and host FIFO model drive the DUT,
// expected bytes are queued per transaction and monitors compare as the DUT presents them.
module tb_spi_slave_ctrl;

    localparam int HP = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_req_data;
    logic [7:0] fifo_din;
    logic       fifo_din_valid;
    logic       fifo_empty;
    logic [7:0] reg_din;
    logic       reg_din_val;
    logic       reg_ack;
    logic       timeout;
    logic       busy;
    logic       interrupt;
    logic [7:0] dout;
    logic       dout_valid;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_ss;

    always #5 clk = ~clk;

    spi_slave_ctrl #(
        .DATA_WIDTH(8),
        .TIMEOUT_DEFAULT(127),
        .TIMEOUT_SCALE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_req_data(fifo_req_data),
        .fifo_din(fifo_din),
        .fifo_din_valid(fifo_din_valid),
        .fifo_empty(fifo_empty),
        .reg_din(reg_din),
        .reg_din_val(reg_din_val),
        .reg_ack(reg_ack),
        .timeout(timeout),
        .busy(busy),
        .interrupt(interrupt),
        .dout(dout),
        .dout_valid(dout_valid),
        .spi_clk(spi_clk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .spi_ss(spi_ss)
    );

    int checks = 0;
    int errors = 0;
    int n_req = 0, n_int = 0, n_to = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_dout[$];
    logic [7:0] exp_miso[$];
    logic [7:0] got_miso[$];
    logic [7:0] tx_b[4];
    logic [7:0] fifo_b[4];
    logic       m_cpol, m_cpha;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Host TX FIFO: answers a request with the head byte during the following half cycle.
    initial begin
        forever begin
            @(negedge clk);
            fifo_din_valid = 1'b0;
            if (rst && fifo_req_data && fifo_q.size() > 0) begin
                fifo_din       = fifo_q.pop_front();
                fifo_din_valid = 1'b1;
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Monitor: pulse counting and scoreboard comparison.
    always @(negedge clk) begin
        if (rst) begin
            if (fifo_req_data) n_req++;
            if (interrupt) n_int++;
            if (timeout) n_to++;
            if (dout_valid) begin
                if (exp_dout.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dout_valid_extra: got %02h expected no pulse", dout);
                end else begin
                    check("dout", 32'(dout), 32'(exp_dout.pop_front()));
                end
            end
            while (got_miso.size() > 0 && exp_miso.size() > 0)
                check("miso_byte", 32'(got_miso.pop_front()), 32'(exp_miso.pop_front()));
        end
    end

    task automatic reg_write(input logic [7:0] d);
        @(negedge clk);
        reg_din     = d;
        reg_din_val = 1'b1;
        @(negedge clk);
        reg_din_val = 1'b0;
        check("reg_ack_pulse", 32'(reg_ack), 32'd1);
        @(negedge clk);
        check("reg_ack_clear", 32'(reg_ack), 32'd0);
    endtask

    task automatic set_mode(input logic cp, input logic ch);
        reg_write({6'b0, cp, ch});
        m_cpol = cp;
        m_cpha = ch;
    endtask

    // Master side of nb bits, MSB first, in the given mode.
    task automatic spi_bits(input logic [7:0] tx, input int nb, input logic cp, input logic ch,
                            output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nb; i++) begin
            if (!ch) begin
                spi_mosi = tx[7-i];
                cyc(HP);
                spi_clk = ~cp;
                rx      = {rx[6:0], spi_miso};
                cyc(HP);
                spi_clk = cp;
            end else begin
                spi_clk  = ~cp;
                spi_mosi = tx[7-i];
                cyc(HP);
                spi_clk = cp;
                rx      = {rx[6:0], spi_miso};
                cyc(HP);
            end
        end
    endtask

    task automatic ss_open(input logic cp, input logic ch);
        spi_clk  = cp;
        spi_mosi = 1'b0;
        cyc(4);
        spi_ss = 1'b0;
        cyc(ch ? 9 : 5);
    endtask

    // One transaction of n bytes from tx_b with k bytes (k <= n+1) preloaded from fifo_b.
    task automatic run_xfer(input int n, input int k);
        logic [7:0] r;
        int r0, i0, t0;
        logic cp, ch;
        cp = m_cpol;
        ch = m_cpha;
        for (int j = 0; j < k; j++) fifo_q.push_back(fifo_b[j]);
        fifo_empty = (k == 0);
        for (int j = 0; j < n; j++) begin
            exp_dout.push_back(tx_b[j]);
            exp_miso.push_back(j < k ? fifo_b[j] : 8'h00);
        end
        r0 = n_req;
        i0 = n_int;
        t0 = n_to;
        ss_open(cp, ch);
        for (int j = 0; j < n; j++) begin
            spi_bits(tx_b[j], 8, cp, ch, r);
            got_miso.push_back(r);
        end
        cyc(HP);
        spi_ss = 1'b1;
        cyc(8);
        check("fifo_req_count", 32'(n_req - r0), 32'((n + 1 < k) ? n + 1 : k));
        check("interrupt_count", 32'(n_int - i0), 32'd1);
        check("no_timeout", 32'(n_to - t0), 32'd0);
        check("busy_after_end", 32'(busy), 32'd0);
        check("dout_outstanding", 32'(exp_dout.size()), 32'd0);
        check("miso_outstanding", 32'(got_miso.size() + exp_miso.size()), 32'd0);
        fifo_q.delete();
        fifo_empty = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        int t0, i0;
        rst            = 1'b1;
        spi_ss         = 1'b1;
        spi_clk        = 1'b0;
        spi_mosi       = 1'b0;
        reg_din        = '0;
        reg_din_val    = 1'b0;
        fifo_empty     = 1'b1;
        fifo_din       = '0;
        fifo_din_valid = 1'b0;
        m_cpol         = 1'b0;
        m_cpha         = 1'b0;
        #2 rst = 1'b0;
        cyc(3);
        check("reset_outputs", 32'({fifo_req_data, reg_ack, timeout, busy, interrupt, dout_valid, spi_miso}), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        rst = 1'b1;
        cyc(5);

        // Mode 0, one byte each way.
        tx_b[0] = 8'h3C; fifo_b[0] = 8'hA5;
        run_xfer(1, 1);

        // Mode 3 via config write.
        set_mode(1'b1, 1'b1);
        tx_b[0] = 8'h96; fifo_b[0] = 8'h96;
        run_xfer(1, 1);

        // Empty FIFO: master reads zeros, no fetch request.
        set_mode(1'b0, 1'b0);
        tx_b[0] = 8'hFF;
        run_xfer(1, 0);

        // Three back-to-back bytes.
        tx_b[0] = 8'h01; tx_b[1] = 8'h02; tx_b[2] = 8'h03;
        fifo_b[0] = 8'h10; fifo_b[1] = 8'h20; fifo_b[2] = 8'h30;
        run_xfer(3, 3);

        // Mode write during a transfer takes effect only for the next transaction.
        tx_b[0] = 8'h5B; fifo_b[0] = 8'hC6;
        fork
            run_xfer(1, 1);
            begin
                cyc(20);
                reg_write(8'h03);
            end
        join
        m_cpol = 1'b1;
        m_cpha = 1'b1;
        tx_b[0] = 8'h2D; fifo_b[0] = 8'hE4;
        run_xfer(1, 1);

        // Inactivity timeout after a partial byte.
        set_mode(1'b0, 1'b0);
        reg_write(8'h81);
        t0 = n_to;
        i0 = n_int;
        ss_open(1'b0, 1'b0);
        spi_bits(8'hB7, 3, 1'b0, 1'b0, r);
        cyc(40);
        check("timeout_once", 32'(n_to - t0), 32'd1);
        check("busy_held_after_timeout", 32'(busy), 32'd1);
        spi_ss = 1'b1;
        cyc(8);
        check("busy_after_timeout_end", 32'(busy), 32'd0);
        check("interrupt_after_timeout", 32'(n_int - i0), 32'd1);
        tx_b[0] = 8'h6E; fifo_b[0] = 8'h4D;
        run_xfer(1, 1);
        reg_write(8'hFF);

        // Reset mid-transaction.
        ss_open(1'b0, 1'b0);
        spi_bits(8'hE1, 4, 1'b0, 1'b0, r);
        rst = 1'b0;
        #1;
        check("midreset_outputs", 32'({fifo_req_data, reg_ack, timeout, busy, interrupt, dout_valid, spi_miso}), 32'd0);
        check("midreset_dout", 32'(dout), 32'd0);
        spi_ss  = 1'b1;
        spi_clk = 1'b0;
        cyc(4);
        rst    = 1'b1;
        m_cpol = 1'b0;
        m_cpha = 1'b0;
        cyc(4);
        check("idle_after_reset", 32'(busy), 32'd0);
        tx_b[0] = 8'hC3; fifo_b[0] = 8'h5A;
        run_xfer(1, 1);

        // Randomised transactions across all modes.
        for (int it = 0; it < 12; it++) begin
            int n, k;
            set_mode(1'($urandom), 1'($urandom));
            n = int'($urandom_range(1, 3));
            k = int'($urandom_range(0, n + 1));
            for (int j = 0; j < 4; j++) begin
                tx_b[j]   = 8'($urandom);
                fifo_b[j] = 8'($urandom);
            end
            run_xfer(n, k);
        end

        cyc(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
